// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipeline stage registers
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 16;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // clear beats increment; increment stops at the all-ones value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry elastic pipeline register with flush, bubble and stall counter
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              out_ready,
   input  logic              flush,
   input  logic              bubble,
   input  logic              clr_count,
   output logic [CNT_W-1:0]  stall_count
);

   stage_state_t      state, state_nxt;
   logic [DATA_W-1:0] main_data, main_data_nxt;
   logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
   logic [DATA_W-1:0] skid_data, skid_data_nxt;
   logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
   logic              accept;
   logic              deliver;

   assign out_valid = (state != EMPTY);
   assign out_data  = main_data;
   // downstream sees a NOP whenever nothing valid is presented
   assign out_ctrl  = out_valid ? main_ctrl : '0;

   assign accept  = in_valid && in_ready && !bubble;
   assign deliver = out_valid && out_ready;

   // state and both entries; in_ready is registered from the next state so it never depends on out_ready
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
         in_ready  <= 1'b0;
      end else begin
         state     <= state_nxt;
         main_data <= main_data_nxt;
         main_ctrl <= main_ctrl_nxt;
         skid_data <= skid_data_nxt;
         skid_ctrl <= skid_ctrl_nxt;
         in_ready  <= (state_nxt != FULL);
      end
   end

   // next state and entry movement; flush overrides every other action
   always_comb begin
      state_nxt     = state;
      main_data_nxt = main_data;
      main_ctrl_nxt = main_ctrl;
      skid_data_nxt = skid_data;
      skid_ctrl_nxt = skid_ctrl;
      if (flush) begin
         state_nxt     = EMPTY;
         main_data_nxt = '0;
         main_ctrl_nxt = '0;
         skid_data_nxt = '0;
         skid_ctrl_nxt = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_data_nxt = in_data;
                  main_ctrl_nxt = in_ctrl;
                  state_nxt     = ONE;
               end
            end
            ONE: begin
               case ({accept, deliver})
                  2'b10: begin
                     skid_data_nxt = in_data;
                     skid_ctrl_nxt = in_ctrl;
                     state_nxt     = FULL;
                  end
                  2'b01: begin
                     state_nxt = EMPTY;
                  end
                  2'b11: begin
                     main_data_nxt = in_data;
                     main_ctrl_nxt = in_ctrl;
                  end
                  default: begin
                  end
               endcase
            end
            FULL: begin
               // older entry leaves first, skid entry moves up to main
               if (deliver) begin
                  main_data_nxt = skid_data;
                  main_ctrl_nxt = skid_ctrl;
                  skid_data_nxt = '0;
                  skid_ctrl_nxt = '0;
                  state_nxt     = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (out_valid && !out_ready),
      .clr   (clr_count),
      .count (stall_count)
   );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath payload width.
REQ-002 SHALL have parameter CTRL_W, default 16, control-bit payload width (branch, jump, mem_wr, etc.).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 SHALL have port: clock  in  1  rising-edge system clock.
REQ-006 SHALL have port: reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: in_valid  in  1  upstream holds a valid instruction.
REQ-008 SHALL have port: in_data  in  DATA_W  upstream payload.
REQ-009 SHALL have port: in_ctrl  in  CTRL_W  upstream control bits.
REQ-010 SHALL have port: in_ready  out  1  stage accepts a transfer this cycle.
REQ-011 SHALL have port: out_valid  out  1  stage presents a valid instruction.
REQ-012 SHALL have port: out_data  out  DATA_W  payload to downstream.
REQ-013 SHALL have port: out_ctrl  out  CTRL_W  control to downstream.
REQ-014 SHALL have port: out_ready  in  1  downstream accepts this cycle.
REQ-015 SHALL have port: flush  in  1  kill all held entries (branch/jump redirect).
REQ-016 SHALL have port: bubble  in  1  block acceptance this cycle (load-use stall injection).
REQ-017 SHALL have port: clr_count  in  1  synchronously zero stall_count.
REQ-018 SHALL have port: stall_count  out  CNT_W  saturating count of downstream-stall cycles.

Function
REQ-019 SHALL implement a 2-entry elastic buffer (main + skid) with states EMPTY, ONE, FULL.
REQ-020 SHALL accept a transfer when in_valid && in_ready && !bubble; it SHALL deliver one when out_valid && out_ready.
REQ-021 SHALL drive in_ready from registered state only (state != FULL), with no combinational path from out_ready.
REQ-022 SHALL present an accepted entry on out_* exactly 1 cycle after acceptance when the stage was EMPTY.
REQ-023 SHALL use these transitions: EMPTY->ONE on accept; ONE->FULL on accept without deliver; ONE->EMPTY on deliver without accept; ONE stays ONE on accept and deliver together; FULL->ONE on deliver.
REQ-024 SHALL preserve FIFO order: after a skid entry is captured, the main entry is delivered first and the skid entry moves to main.
REQ-025 SHALL hold out_data and out_ctrl stable while out_valid && !out_ready.
REQ-026 SHALL, while out_valid is 0, drive out_ctrl to all zeros so that downstream sees a NOP.
REQ-027 SHALL, on flush, go to EMPTY on the next edge, zero both entries, and discard any same-cycle accept; flush SHALL take priority over bubble, accept and deliver.
REQ-028 SHALL, on bubble, ignore in_valid while still allowing delivery, so that a FULL or ONE stage drains.
REQ-029 SHALL increment stall_count in each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1; clr_count SHALL win over increment.

Reset
REQ-030 SHALL, while reset is 0, asynchronously force state EMPTY, out_valid 0, in_ready 0, out_data 0, out_ctrl 0, both entries 0, and stall_count 0.
REQ-031 SHALL drive in_ready 1 on the first edge after reset deasserts.
REQ-032 SHALL treat reset mid-operation as discarding all entries, with no partial transfer visible downstream.

Structure
REQ-033 SHALL take the state enum (EMPTY/ONE/FULL) and the default DATA_W/CTRL_W/CNT_W constants from shared package pipe_pkg.
REQ-034 SHALL implement the saturating counter as sub-module sat_counter (parameter CNT_W; ports inc, clr, count).
REQ-035 SHALL be instantiable once per pipe boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with only parameter changes.

Verification
REQ-036 Streaming: in_valid=1 for 8 cycles with data 0x10..0x17, out_ready=1 -> out_data shows 0x10..0x17 on consecutive cycles, 1-cycle latency, no gaps.
REQ-037 Backpressure: accept 0xA1, 0xA2 with out_ready=0 -> FULL, in_ready=0, out_data holds 0xA1, stall_count increments each cycle; then out_ready=1 -> 0xA1 then 0xA2 delivered, in_ready=1 again.
REQ-038 Flush: FULL with 0xB1/0xB2, assert flush plus in_valid with 0xB3 -> next cycle out_valid=0, out_ctrl=0, and 0xB3 is never delivered.
REQ-039 Bubble: ONE with 0xC1, bubble=1 with in_valid=1 (0xC2), out_ready=1 -> 0xC1 delivered, state EMPTY, 0xC2 not captured.
REQ-040 Saturation/reset: CNT_W=4, stall 20 cycles -> stall_count=15; clr_count -> 0; assert reset mid-FULL -> all outputs 0 immediately, without waiting for a clock edge.
